tb_mem_responder: RTL and testbench
===================================

// Module: tb_mem_responder
// PURPOSE
// - Behavioural memory slave for CPU test benches. Runs off tb_clk and consumes the same reset as the bench.
// - Answers req/ack read and write accesses from the CPU under test with a configurable number of wait states.
// - stall adds extra wait cycles on demand. A wrapping access counter reports how many accesses have completed.
// PARAMETERS
// - ADDR_WIDTH   16  width of addr port
// - DATA_WIDTH   8   width of wdata/rdata
// - MEM_BITS     16  memory holds 2**MEM_BITS words; addr[MEM_BITS-1:0] indexes it (MEM_BITS <= ADDR_WIDTH)
// - WAIT_STATES  2   base wait cycles per access, 0..255
// PORTS
// - tb_clk        in   1           bench clock; all logic is on its rising edge
// - reset         in   1           synchronous, active-high
// - req           in   1           access request; held until ack
// - we            in   1           1 = write, 0 = read; sampled at accept
// - addr          in   ADDR_WIDTH  access address; sampled at accept
// - wdata         in   DATA_WIDTH  write data; sampled at accept
// - stall         in   1           1 = freeze the wait countdown this cycle
// - ack           out  1           one-cycle completion pulse
// - rdata         out  DATA_WIDTH  read data; valid with ack, held until next read ack
// - busy          out  1           high from accept through the ack cycle
// - access_count  out  16          completed accesses (reads and writes)
// BEHAVIOUR
// - Reset is synchronous, active-high, clock tb_clk.
//   - Reset values: ack=0, busy=0, rdata=0, access_count=0, state=IDLE, wait counter=0.
//   - Memory contents are not touched by reset.
// - Reset mid-access aborts the access:
//   - no write is performed and no ack is issued;
//   - the block is in IDLE after the reset edge.
// - States:
//   - IDLE: busy=0. On an edge with req=1, latch we/addr/wdata and set cnt=WAIT_STATES, then:
//     - WAIT_STATES=0 -> go to ACK;
//     - otherwise -> go to WAIT with busy=1.
//   - WAIT: on each edge, stall=1 holds cnt; stall=0 decrements it. When cnt reaches 0 (cnt==1 and stall=0), go to ACK.
//   - ACK: state lasts exactly one cycle with ack=1 and busy=1, then returns to IDLE.
//     - On the edge entering ACK: a write updates mem[latched addr]; a read loads rdata from mem[latched addr]; access_count increments.
//     - stall is ignored in ACK.
// - Latency:
//   - Accept on edge N; ack is high in the cycle after edge N+1+WAIT_STATES+S, where S = number of stalled WAIT edges.
// - Input changes after accept are ignored: the latched values are used for the whole access.
// - req during a non-IDLE state is not a new request; the requester holds req until ack.
// - Back-to-back: if req is still high at the IDLE edge that follows ack, a new access is accepted. A requester wanting one access drops req in the ack cycle.
// - Address wrap: bits of addr above MEM_BITS are ignored (0x1_0005 with MEM_BITS=16 hits word 0x0005).
// - Write data is not forwarded to rdata on a write ack (rdata keeps its last read value).
// - Read-after-write to the same address returns the new data.
// - access_count wraps 0xFFFF -> 0x0000.
// - Same-edge events: reset has priority over req and stall; stall has priority over the decrement.
// TESTING
// 1. Reset, W=2: write 0x3C to 0x0010 (req held) -> ack in 4th cycle after accept edge; access_count=1; rdata stays 0x00.
// 2. Read 0x0010 -> ack after the same latency; rdata=0x3C with ack and held after ack falls; access_count=2.
// 3. WAIT_STATES=0: read accepted at edge N -> ack in cycle after edge N+1; busy high for exactly 1 cycle.
// 4. W=2, stall high for 3 WAIT edges -> ack delayed by exactly 3 cycles vs scenario 2; rdata still correct.
// 5. req held through ack -> second access accepted at the next edge, no dead cycle; access_count rises by 2. Write to 0x1_0005 then read 0x0005 -> same data.
// 6. Assert reset during WAIT of a write of 0xAA to 0x0020 -> no ack; all outputs at reset values next cycle; later read of 0x0020 returns the old value. Separately: force 0xFFFF completions -> access_count=0xFFFF, next ack -> 0x0000.

Source files
------------

// File: rtl/tb_mem_responder.sv
// Behavioural memory slave for CPU benches: req/ack handshake with
// configurable wait states, a stall input and a wrapping completion counter.
module tb_mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_BITS    = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  tb_clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  stall,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [15:0]           access_count
);

  localparam logic [7:0] WS = 8'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic                  we_p0;
  logic [MEM_BITS-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_BITS)-1];
  logic                  addr_hi_unused;

  // Upper address bits beyond the memory size are deliberately ignored.
  assign addr_hi_unused = ^addr;

  // Stage p0: access attributes captured at accept, held for the whole access.
  always_ff @(posedge tb_clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      addr_p0  <= addr[MEM_BITS-1:0];
      wdata_p0 <= wdata;
    end
  end

  // ACK state is the final edge before the ack pulse; a reset on that edge
  // must still suppress the write.
  always_ff @(posedge tb_clk) begin
    if (state == ACK && we_p0 && !reset)
      mem[addr_p0] <= wdata_p0;
  end

  // Control FSM: ack/busy/rdata/access_count are registered outputs. During
  // the ack cycle the FSM is already back in IDLE, so a held req is taken
  // at the very next edge without a dead cycle.
  always_ff @(posedge tb_clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      access_count <= 16'd0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WS;
            busy  <= (WS != 8'd0);
            state <= (WS == 8'd0) ? ACK : WAIT;
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          if (!stall) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1)
              state <= ACK;
          end
        end
        ACK: begin
          ack          <= 1'b1;
          busy         <= 1'b1;
          access_count <= access_count + 16'd1;
          if (!we_p0)
            rdata <= mem[addr_p0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_mem_responder.sv
// Bench for tb_mem_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_tb_mem_responder;

  logic        tb_clk;
  logic        reset;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [19:0] addr_s  [2];
  logic [7:0]  wdata_s [2];
  logic        stall_s [2];
  logic        ack_s   [2];
  logic        busy_s  [2];
  logic [7:0]  rdata_s [2];
  logic [15:0] cnt_s   [2];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  tb_mem_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .MEM_BITS(16), .WAIT_STATES(2)) u_dut2 (
    .tb_clk(tb_clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .stall(stall_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]),
    .busy(busy_s[0]), .access_count(cnt_s[0]));

  tb_mem_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .MEM_BITS(16), .WAIT_STATES(0)) u_dut0 (
    .tb_clk(tb_clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .stall(stall_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]),
    .busy(busy_s[1]), .access_count(cnt_s[1]));

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Transaction-level model: an access completes once WAIT_STATES unstalled
  // edges have elapsed after accept, plus one final edge that ignores stall.
  logic        m_pend [2];
  logic        m_we   [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wd   [2];
  int          m_left [2];
  logic        m_ack  [2];
  logic        m_busy [2];
  logic [7:0]  m_rdata[2];
  logic [15:0] m_cnt  [2];
  logic [7:0]  mem_m  [int];

  function automatic int wst(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  always @(posedge tb_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pend[i] = 1'b0; m_ack[i] = 1'b0; m_busy[i] = 1'b0;
        m_rdata[i] = 8'h00; m_cnt[i] = 16'h0000;
      end else if (!m_pend[i]) begin
        m_ack[i]  = 1'b0;
        m_busy[i] = 1'b0;
        if (req_s[i]) begin
          m_pend[i] = 1'b1; m_we[i] = we_s[i]; m_addr[i] = addr_s[i][15:0];
          m_wd[i] = wdata_s[i]; m_left[i] = wst(i); m_busy[i] = (wst(i) != 0);
        end
      end else if (m_left[i] > 0) begin
        if (!stall_s[i]) m_left[i] = m_left[i] - 1;
      end else begin
        if (m_we[i]) mem_m[i*65536 + int'(m_addr[i])] = m_wd[i];
        else         m_rdata[i] = mem_m[i*65536 + int'(m_addr[i])];
        m_ack[i] = 1'b1; m_busy[i] = 1'b1; m_cnt[i] = m_cnt[i] + 16'd1; m_pend[i] = 1'b0;
      end
    end
  end

  always @(negedge tb_clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (ack_s[i] !== m_ack[i] || busy_s[i] !== m_busy[i] ||
            rdata_s[i] !== m_rdata[i] || cnt_s[i] !== m_cnt[i]) begin
          miscompares++;
          $display("FAIL model_cmp inst%0d t=%0t ack/busy/rdata/count got %b/%b/%h/%h expected %b/%b/%h/%h",
                   i, $time, ack_s[i], busy_s[i], rdata_s[i], cnt_s[i],
                   m_ack[i], m_busy[i], m_rdata[i], m_cnt[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT able to accept at the next edge.
  // lat = index of the cycle after accept in which ack is seen.
  task automatic do_access(input int i, input logic w, input logic [19:0] a,
                           input logic [7:0] d, input logic [15:0] smask,
                           input bit hold, input bit scramble,
                           output int lat, output int busy_cyc);
    req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d; stall_s[i] = 1'b0;
    lat = -1; busy_cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge tb_clk);
      if (busy_s[i]) busy_cyc++;
      if (ack_s[i]) begin
        lat = k;
        break;
      end
      stall_s[i] = (k <= 16) ? smask[k-1] : 1'b0;
      if (scramble) begin
        we_s[i] = 1'($urandom); addr_s[i] = 20'($urandom); wdata_s[i] = 8'($urandom);
      end
    end
    stall_s[i] = 1'b0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout inst%0d: no ack within 64 cycles", i);
    end
    if (!hold || lat < 0) req_s[i] = 1'b0;
  endtask

  int lat, bc, c0;
  logic [19:0] ra;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0; stall_s[i] = 1'b0;
    end
    @(posedge tb_clk);
    chk_en = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check("reset_ack", int'(ack_s[0]), 0);
    check("reset_busy", int'(busy_s[0]), 0);
    check("reset_rdata", int'(rdata_s[0]), 0);
    check("reset_count", int'(cnt_s[0]), 0);
    reset = 1'b0;

    // Write then read, 2 wait states.
    do_access(0, 1'b1, 20'h00010, 8'h3C, 16'h0, 0, 0, lat, bc);
    check("wr_latency", lat, 4);
    check("wr_busy_cycles", bc, 4);
    check("wr_count", int'(cnt_s[0]), 1);
    check("wr_rdata_kept", int'(rdata_s[0]), 0);
    do_access(0, 1'b0, 20'h00010, 8'h00, 16'h0, 0, 1, lat, bc);
    check("rd_latency", lat, 4);
    check("rd_rdata_ack", int'(rdata_s[0]), 8'h3C);
    @(negedge tb_clk);
    check("rd_ack_falls", int'(ack_s[0]), 0);
    check("rd_rdata_held", int'(rdata_s[0]), 8'h3C);
    check("rd_count", int'(cnt_s[0]), 2);

    // Zero wait states.
    do_access(1, 1'b1, 20'h00040, 8'h5A, 16'h0, 0, 0, lat, bc);
    do_access(1, 1'b0, 20'h00040, 8'h00, 16'h0, 0, 1, lat, bc);
    check("w0_latency", lat, 2);
    check("w0_busy_cycles", bc, 1);
    check("w0_rdata", int'(rdata_s[1]), 8'h5A);

    // Three stalled WAIT edges.
    do_access(0, 1'b0, 20'h00010, 8'h00, 16'h0007, 0, 0, lat, bc);
    check("stall_latency", lat, 7);
    check("stall_rdata", int'(rdata_s[0]), 8'h3C);

    // Back-to-back with address wrap.
    c0 = int'(cnt_s[0]);
    do_access(0, 1'b1, 20'h10005, 8'h77, 16'h0, 1, 0, lat, bc);
    check("b2b_first_latency", lat, 4);
    do_access(0, 1'b0, 20'h00005, 8'h00, 16'h0, 0, 0, lat, bc);
    check("b2b_second_latency", lat, 4);
    check("b2b_wrap_rdata", int'(rdata_s[0]), 8'h77);
    check("b2b_count", int'(cnt_s[0]), c0 + 2);

    // Reset aborts a write in progress.
    do_access(0, 1'b1, 20'h00020, 8'h55, 16'h0, 0, 0, lat, bc);
    @(negedge tb_clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 20'h00020; wdata_s[0] = 8'hAA;
    @(negedge tb_clk);
    check("abort_busy_before", int'(busy_s[0]), 1);
    reset = 1'b1;
    @(negedge tb_clk);
    reset = 1'b0; req_s[0] = 1'b0;
    check("abort_ack", int'(ack_s[0]), 0);
    check("abort_busy", int'(busy_s[0]), 0);
    check("abort_rdata", int'(rdata_s[0]), 0);
    check("abort_count", int'(cnt_s[0]), 0);
    do_access(0, 1'b0, 20'h00020, 8'h00, 16'h0, 0, 0, lat, bc);
    check("abort_old_data", int'(rdata_s[0]), 8'h55);

    // Counter wrap.
    @(negedge tb_clk);
    #2;
    force u_dut2.access_count = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    #1;
    release u_dut2.access_count;
    @(negedge tb_clk);
    check("count_ffff", int'(cnt_s[0]), 16'hFFFF);
    do_access(0, 1'b0, 20'h00010, 8'h00, 16'h0, 0, 0, lat, bc);
    check("count_wrap", int'(cnt_s[0]), 0);

    // Randomized traffic on both instances over a preloaded address window.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++)
        do_access(i, 1'b1, 20'h00100 + 20'(k), 8'($urandom), 16'h0, 0, 0, lat, bc);
      for (int n = 0; n < 60; n++) begin
        bit hold;
        hold = (n != 59) && ($urandom_range(0, 3) == 0);
        ra = {4'($urandom), 12'h010, 4'($urandom)};
        do_access(i, 1'($urandom), ra, 8'($urandom), 16'($urandom & $urandom),
                  hold, 1, lat, bc);
        if (!hold) repeat ($urandom_range(0, 2)) @(negedge tb_clk);
      end
    end

    repeat (3) @(negedge tb_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
